wb_scheduler: RTL and testbench

//  Owns the regfile write port. Arbitrates round-robin between ALU and LSU writeback sources (valid/ready), registers the winner onto writepass/waddr/wdata.

---
 rtl/wb_scheduler.sv | 140 ++++++++++++++
 tb/tb_wb_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scheduler.sv
// Writeback scheduler: round-robin ALU/LSU arbitration onto the regfile write port,
// plus a per-register pending-write scoreboard that drives the decode read hazard.
module wb_scheduler #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            writepass,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata,
    input  logic            rs1pass,
    input  logic [4:0]      rs1addr,
    input  logic            rs2pass,
    input  logic [4:0]      rs2addr,
    output logic            hazard,
    output logic [31:0]     busy,
    output logic            sb_err
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic             last_lsu_q, last_lsu_d;
    logic             writepass_q, writepass_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             sb_err_q, sb_err_d;

    logic             alu_grant, lsu_grant, xfer;
    logic [4:0]       xfer_rd;
    logic [XLEN-1:0]  xfer_data;
    logic             issue_inc;
    logic             rs1_pend, rs2_pend;

    // Both valid: grant whichever source did not win last time.
    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (!rst) begin
            if (alu_valid && (!lsu_valid || last_lsu_q)) begin
                alu_grant = 1'b1;
            end else if (lsu_valid) begin
                lsu_grant = 1'b1;
            end
        end
    end

    assign xfer      = alu_grant | lsu_grant;
    assign xfer_rd   = alu_grant ? alu_rd : lsu_rd;
    assign xfer_data = alu_grant ? alu_data : lsu_data;

    always_comb begin
        writepass_d = xfer && (xfer_rd != 5'd0);
        waddr_d     = writepass_d ? xfer_rd : waddr_q;
        wdata_d     = writepass_d ? xfer_data : wdata_q;
        last_lsu_d  = lsu_grant ? 1'b1 : (alu_grant ? 1'b0 : last_lsu_q);
    end

    assign issue_ready = !rst && ((issue_rd == 5'd0) || (cnt_q[issue_rd] != CntMax));
    assign issue_inc   = issue_valid && issue_ready && (issue_rd != 5'd0);

    // Simultaneous issue and commit on one register cancel out.
    always_comb begin
        sb_err_d = sb_err_q;
        for (int i = 0; i < 32; i++) begin
            logic inc, dec;
            inc      = issue_inc && (issue_rd == 5'(i));
            dec      = writepass_q && (waddr_q == 5'(i)) && (i != 0);
            cnt_d[i] = cnt_q[i];
            if (dec && (cnt_q[i] == '0)) begin
                sb_err_d = 1'b1;
            end else if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            writepass_q <= 1'b0;
            waddr_q     <= 5'd0;
            wdata_q     <= '0;
            last_lsu_q  <= 1'b1;
            sb_err_q    <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            writepass_q <= writepass_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            last_lsu_q  <= last_lsu_d;
            sb_err_q    <= sb_err_d;
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A last outstanding write committing this cycle is bypassed by the regfile.
    always_comb begin
        rs1_pend = (cnt_q[rs1addr] > CntOne) ||
                   ((cnt_q[rs1addr] == CntOne) && !(writepass_q && (waddr_q == rs1addr)));
        rs2_pend = (cnt_q[rs2addr] > CntOne) ||
                   ((cnt_q[rs2addr] == CntOne) && !(writepass_q && (waddr_q == rs2addr)));
        hazard   = !rst && ((rs1pass && (rs1addr != 5'd0) && rs1_pend) ||
                            (rs2pass && (rs2addr != 5'd0) && rs2_pend));
    end

    always_comb begin
        busy = '0;
        for (int i = 1; i < 32; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

    assign alu_ready = alu_grant;
    assign lsu_ready = lsu_grant;
    assign writepass = writepass_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_wb_scheduler.sv
// Bench for wb_scheduler: per-cycle comparison against a behavioural scoreboard model,
// plus directed scenarios with literal expectations.
module tb_wb_scheduler;

    localparam int MaxCnt = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        lsu_ready;
    logic        writepass;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rs1pass = 1'b0;
    logic [4:0]  rs1addr = '0;
    logic        rs2pass = 1'b0;
    logic [4:0]  rs2addr = '0;
    logic        hazard;
    logic [31:0] busy;
    logic        sb_err;

    int n_cmp = 0;
    int n_err = 0;
    bit armed = 1'b0;

    wb_scheduler #(.XLEN(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .writepass(writepass), .waddr(waddr), .wdata(wdata),
        .rs1pass(rs1pass), .rs1addr(rs1addr), .rs2pass(rs2pass), .rs2addr(rs2addr),
        .hazard(hazard), .busy(busy), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Model state: outstanding writes per register, the write port, arbitration preference.
    int          m_cnt [32];
    bit          m_wp = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;
    bit          m_prefer_alu = 1'b1;
    bit          m_err = 1'b0;

    function automatic bit pend(input logic [4:0] a);
        return (m_cnt[a] > 1) || (m_cnt[a] == 1 && !(m_wp && m_wa == a));
    endfunction

    always @(negedge clk) begin : model
        bit          e_alu, e_lsu, e_ir, e_hz, x;
        logic [31:0] e_busy;
        logic [4:0]  x_rd;
        logic [31:0] x_data;
        e_alu = 1'b0;
        e_lsu = 1'b0;
        if (!rst) begin
            if (alu_valid && lsu_valid) begin
                e_alu = m_prefer_alu;
                e_lsu = !m_prefer_alu;
            end else begin
                e_alu = alu_valid;
                e_lsu = lsu_valid;
            end
        end
        e_ir = !rst && (issue_rd == 0 || m_cnt[issue_rd] < MaxCnt);
        e_hz = !rst && ((rs1pass && rs1addr != 0 && pend(rs1addr)) ||
                        (rs2pass && rs2addr != 0 && pend(rs2addr)));
        e_busy = '0;
        for (int i = 1; i < 32; i++) e_busy[i] = (m_cnt[i] != 0);

        if (armed) begin
            chk("alu_ready", 32'(alu_ready), 32'(e_alu));
            chk("lsu_ready", 32'(lsu_ready), 32'(e_lsu));
            chk("issue_ready", 32'(issue_ready), 32'(e_ir));
            chk("hazard", 32'(hazard), 32'(e_hz));
            chk("writepass", 32'(writepass), 32'(m_wp));
            if (m_wp) begin
                chk("waddr", 32'(waddr), 32'(m_wa));
                chk("wdata", wdata, m_wd);
            end
            chk("busy", busy, e_busy);
            chk("sb_err", 32'(sb_err), 32'(m_err));
        end

        if (rst) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_wp = 1'b0;
            m_prefer_alu = 1'b1;
            m_err = 1'b0;
        end else begin
            if (m_wp) begin
                if (m_cnt[m_wa] == 0) m_err = 1'b1;
                else m_cnt[m_wa]--;
            end
            if (issue_valid && e_ir && issue_rd != 0) begin
                // A commit to an empty counter leaves it at zero even with an issue.
                if (!(m_wp && m_wa == issue_rd && m_cnt[issue_rd] == 0 && !m_err_pre(issue_rd)))
                    m_cnt[issue_rd]++;
            end
            x      = e_alu || e_lsu;
            x_rd   = e_alu ? alu_rd : lsu_rd;
            x_data = e_alu ? alu_data : lsu_data;
            m_wp   = x && x_rd != 0;
            if (m_wp) begin
                m_wa = x_rd;
                m_wd = x_data;
            end
            if (x) m_prefer_alu = e_lsu;
        end
    end

    // True when the register had a write outstanding before this cycle's commit.
    bit m_had [32];
    always @(posedge clk) for (int i = 0; i < 32; i++) m_had[i] = (m_cnt[i] != 0);
    function automatic bit m_err_pre(input logic [4:0] a);
        return m_had[a];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] pat;
        bit         got_alu;
        // 1: reset with requests present
        alu_valid = 1'b1; lsu_valid = 1'b1; issue_valid = 1'b1; issue_rd = 5'd3;
        @(posedge clk);
        #1 armed = 1'b1;
        @(negedge clk);
        chk("t1_alu_ready_rst", 32'(alu_ready), 32'd0);
        chk("t1_lsu_ready_rst", 32'(lsu_ready), 32'd0);
        chk("t1_issue_ready_rst", 32'(issue_ready), 32'd0);
        tick;
        rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
        @(negedge clk);
        chk("t1_writepass", 32'(writepass), 32'd0);
        chk("t1_busy", busy, 32'd0);
        chk("t1_sb_err", 32'(sb_err), 32'd0);

        // 2: issue, ALU writeback, hazard resolution
        tick; issue_valid = 1'b1; issue_rd = 5'd5;
        tick; issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        rs1pass = 1'b1; rs1addr = 5'd5;
        @(negedge clk);
        chk("t2_alu_ready", 32'(alu_ready), 32'd1);
        chk("t2_hazard_n", 32'(hazard), 32'd1);
        tick; alu_valid = 1'b0;
        @(negedge clk);
        chk("t2_writepass", 32'(writepass), 32'd1);
        chk("t2_waddr", 32'(waddr), 32'd5);
        chk("t2_wdata", wdata, 32'hDEADBEEF);
        chk("t2_hazard_n1", 32'(hazard), 32'd0);
        tick;
        @(negedge clk);
        chk("t2_busy5", 32'(busy[5]), 32'd0);
        rs1pass = 1'b0;

        // 3: contention alternates, losers hold their data
        tick; rst = 1'b1;
        tick; rst = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd1;
        tick;
        tick; issue_rd = 5'd2;
        tick;
        tick; issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA0000000;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h10000000;
        pat = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_alu_grant", 32'(alu_ready), 32'(pat[k]));
            chk("t3_lsu_grant", 32'(lsu_ready), 32'(!pat[k]));
            got_alu = alu_ready;
            tick;
            if (got_alu) alu_data = alu_data + 1;
            else lsu_data = lsu_data + 1;
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        chk("t3_last_waddr", 32'(waddr), 32'd2);
        chk("t3_last_wdata", wdata, 32'h10000001);
        tick;
        @(negedge clk);
        chk("t3_busy_clear", busy, 32'd0);

        // 4: saturation of rd 7 and release by one commit
        tick; issue_valid = 1'b1; issue_rd = 5'd7;
        tick;
        tick;
        tick; rs2pass = 1'b1; rs2addr = 5'd7;
        @(negedge clk);
        chk("t4_issue_ready_sat", 32'(issue_ready), 32'd0);
        chk("t4_busy7", 32'(busy[7]), 32'd1);
        chk("t4_hazard_rs2", 32'(hazard), 32'd1);
        tick; issue_valid = 1'b0; rs2pass = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h00007777;
        @(negedge clk);
        chk("t4_lsu_ready", 32'(lsu_ready), 32'd1);
        tick; lsu_valid = 1'b0;
        tick; issue_valid = 1'b1; issue_rd = 5'd7;
        @(negedge clk);
        chk("t4_issue_ready_free", 32'(issue_ready), 32'd1);
        tick; issue_valid = 1'b0;

        // 5: underflow commit and rd 0 transfer
        tick; rst = 1'b1;
        tick; rst = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h00000099;
        @(negedge clk);
        chk("t5_alu_ready", 32'(alu_ready), 32'd1);
        tick; alu_valid = 1'b0;
        @(negedge clk);
        chk("t5_waddr", 32'(waddr), 32'd9);
        tick;
        @(negedge clk);
        chk("t5_sb_err", 32'(sb_err), 32'd1);
        chk("t5_busy9", 32'(busy[9]), 32'd0);
        tick; alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        @(negedge clk);
        chk("t5_rd0_ready", 32'(alu_ready), 32'd1);
        tick; alu_valid = 1'b0;
        @(negedge clk);
        chk("t5_rd0_writepass", 32'(writepass), 32'd0);
        chk("t5_sb_err_sticky", 32'(sb_err), 32'd1);

        // 6: reset while a write is on the port
        tick; rst = 1'b1;
        tick; rst = 1'b0; issue_valid = 1'b1; issue_rd = 5'd3;
        tick; issue_rd = 5'd4;
        tick; issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        tick; rst = 1'b1; alu_rd = 5'd0; lsu_valid = 1'b1; lsu_rd = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd4; rs1pass = 1'b1; rs1addr = 5'd4;
        @(negedge clk);
        chk("t6_writepass_pre", 32'(writepass), 32'd1);
        chk("t6_alu_ready_rst", 32'(alu_ready), 32'd0);
        chk("t6_issue_ready_rst", 32'(issue_ready), 32'd0);
        chk("t6_hazard_rst", 32'(hazard), 32'd0);
        tick; rst = 1'b0; issue_valid = 1'b0;
        @(negedge clk);
        chk("t6_writepass", 32'(writepass), 32'd0);
        chk("t6_busy", busy, 32'd0);
        chk("t6_alu_first", 32'(alu_ready), 32'd1);
        chk("t6_lsu_wait", 32'(lsu_ready), 32'd0);
        tick; alu_valid = 1'b0; lsu_valid = 1'b0; rs1pass = 1'b0;
        tick;
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
